rgb_pwm_driver: RTL and testbench

Downstream stage of the colour-fade generator. Takes three duty values (R, G, B) in the range 0..PWM_INTERVAL and produces three PWM waveforms that drive the board RGB LED pins. Duty updates are double-buffered and only take effect at a PWM period boundary, so a waveform never glitches mid-period. A period-start strobe is exported so upstream stages can pace their updates.

---
 rtl/rgb_pwm_pkg.sv | 13 +
 rtl/rgb_pwm_driver_if.sv | 23 ++
 rtl/rgb_pwm_driver_pwm_channel.sv | 44 ++++
 rtl/rgb_pwm_driver.sv | 86 ++++++++
 tb/tb_rgb_pwm_driver.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared helpers for the RGB PWM driver: duty saturation and LED-off level.
package rgb_pwm_pkg;

  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned limit);
    return (duty > limit) ? limit : duty;
  endfunction

  // Pin level that turns an LED off for the chosen pin polarity.
  function automatic logic led_off(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Duty-update bus between the colour-fade generator (master) and the PWM driver (slave).
// duty_load is a valid-only strobe: the driver is always ready, so duty_r/g/b are
// taken on every cycle duty_load is high; period_start is a one-cycle pacing pulse
// back to the master and carries no backpressure.
interface rgb_pwm_driver_if #(
  parameter int DW = 11
);
  logic          duty_load;
  logic [DW-1:0] duty_r;
  logic [DW-1:0] duty_g;
  logic [DW-1:0] duty_b;
  logic          period_start;

  modport master (
    output duty_load, duty_r, duty_g, duty_b,
    input  period_start
  );

  modport slave (
    input  duty_load, duty_r, duty_g, duty_b,
    output period_start
  );
endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM colour channel: double-buffered duty (pending/active) and registered compare.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int          DW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] cnt,
  input  logic          wrap,
  input  logic          duty_load,
  input  logic [DW-1:0] duty,
  output logic          led
);

  localparam logic LED_OFF = led_off(ACTIVE_LOW);

  logic [DW-1:0] duty_c;
  logic [DW-1:0] pend;
  logic [DW-1:0] act;

  assign duty_c = DW'(clamp_duty(32'(duty), PWM_INTERVAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      act  <= '0;
      led  <= LED_OFF;
    end else begin
      if (duty_load) begin
        pend <= duty_c;
      end
      // A load landing on the wrap cycle bypasses pending so it is not a period late.
      if (wrap) begin
        act <= duty_load ? duty_c : pend;
      end
      led <= en ? ((cnt < act) ^ ACTIVE_LOW) : LED_OFF;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM driver: shared period counter, wrap detection and period_start strobe
// feeding three glitch-free PWM channels.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int          DW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  rgb_pwm_driver_if.slave     bus,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b
);

  logic [DW-1:0] cnt;
  logic          wrap;
  logic          period_start_q;

  assign wrap             = en && (cnt == DW'(PWM_INTERVAL - 1));
  assign bus.period_start = period_start_q;

  // Counter parks at 0 while disabled so re-enabling always starts a fresh period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      period_start_q <= 1'b0;
    end else begin
      if (!en || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
      period_start_q <= en && (cnt == '0);
    end
  end

  pwm_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .ACTIVE_LOW   (ACTIVE_LOW),
    .DW           (DW)
  ) u_red (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cnt       (cnt),
    .wrap      (wrap),
    .duty_load (bus.duty_load),
    .duty      (bus.duty_r),
    .led       (led_r)
  );

  pwm_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .ACTIVE_LOW   (ACTIVE_LOW),
    .DW           (DW)
  ) u_green (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cnt       (cnt),
    .wrap      (wrap),
    .duty_load (bus.duty_load),
    .duty      (bus.duty_g),
    .led       (led_g)
  );

  pwm_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .ACTIVE_LOW   (ACTIVE_LOW),
    .DW           (DW)
  ) u_blue (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cnt       (cnt),
    .wrap      (wrap),
    .duty_load (bus.duty_load),
    .duty      (bus.duty_b),
    .led       (led_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver with a 10-clock period and active-low pins, checked
// against a period-level reference model.
module tb_rgb_pwm_driver;

  localparam int PI = 10;
  localparam int DW = 4;

  logic clk;
  logic rst_n;
  logic en;
  logic led_r, led_g, led_b;

  rgb_pwm_driver_if #(.DW(DW)) bus ();

  rgb_pwm_driver #(
    .PWM_INTERVAL (PI),
    .ACTIVE_LOW   (1'b1),
    .DW           (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus),
    .led_r (led_r),
    .led_g (led_g),
    .led_b (led_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: position within the period, and the duty each colour will
  // show this period (act) and next period (pend); on-clocks lead the period.
  int   m_phase;
  int   m_pend[3];
  int   m_act[3];
  logic [3:0] exp_v;
  wire  [3:0] obs = {led_r, led_g, led_b, bus.period_start};

  task automatic model_reset();
    m_phase = 0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0;
      m_act[i]  = 0;
    end
    exp_v = 4'b1110;
  endtask

  task automatic model_update(input bit ld, input int r, input int g, input int b);
    int d[3];
    bit period_end;
    d[0] = r; d[1] = g; d[2] = b;
    if (!rst_n) begin
      model_reset();
      return;
    end
    period_end = en && (m_phase == PI - 1);
    for (int i = 0; i < 3; i++) begin
      exp_v[3 - i] = (en && (m_phase < m_act[i])) ? 1'b0 : 1'b1;
    end
    exp_v[0] = en && (m_phase == 0);
    for (int i = 0; i < 3; i++) begin
      int cd;
      cd = (d[i] > PI) ? PI : d[i];
      if (period_end) m_act[i] = ld ? cd : m_pend[i];
      if (ld) m_pend[i] = cd;
    end
    m_phase = en ? (m_phase + 1) % PI : 0;
  endtask

  // driver: one clock with an optional duty load, model advanced in lock-step
  task automatic step(input bit ld, input int r, input int g, input int b);
    bus.duty_load = ld;
    bus.duty_r    = 4'(r);
    bus.duty_g    = 4'(g);
    bus.duty_b    = 4'(b);
    @(posedge clk);
    model_update(ld, r, g, b);
    #1;
    bus.duty_load = 1'b0;
  endtask

  task automatic test_reset();
    int ps_count;
    rst_n = 1'b0;
    en    = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0);
      checks++;
      if (obs !== 4'b1110) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b want 1110", k, obs);
      end
    end
    rst_n = 1'b1;
    ps_count = 0;
    for (int k = 0; k < 2 * PI; k++) begin
      step(0, 0, 0, 0);
      ps_count += obs[0];
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_release cyc %0d got %b want %b", k, obs, exp_v);
      end
    end
    checks++;
    if (ps_count != 2) begin
      errors++;
      $display("FAIL reset_ps_count got %0d want 2", ps_count);
    end
  endtask

  task automatic run_to_phase(input int target, input string tag);
    for (int k = 0; k < PI && m_phase != target; k++) begin
      step(0, 0, 0, 0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s_align got %b want %b", tag, obs, exp_v);
      end
    end
  endtask

  // one full period from its first clock, counting on-clocks (pin low) per colour
  task automatic run_period(input string tag, output int lows[3]);
    for (int i = 0; i < 3; i++) lows[i] = 0;
    for (int k = 0; k < PI; k++) begin
      step(0, 0, 0, 0);
      lows[0] += int'(!led_r);
      lows[1] += int'(!led_g);
      lows[2] += int'(!led_b);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s_cycle %0d got %b want %b", tag, k, obs, exp_v);
      end
    end
  endtask

  task automatic test_basic_duty();
    int lows[3];
    run_to_phase(4, "basic");
    step(1, 3, 0, 10);
    checks++;
    if (obs[3:1] !== 3'b111) begin
      errors++;
      $display("FAIL basic_no_midperiod got %b want 111", obs[3:1]);
    end
    run_to_phase(0, "basic");
    run_period("basic", lows);
    checks++;
    if (lows[0] != 3 || lows[1] != 0 || lows[2] != 10) begin
      errors++;
      $display("FAIL basic_on_counts got %0d/%0d/%0d want 3/0/10", lows[0], lows[1], lows[2]);
    end
  endtask

  task automatic test_clamp();
    int lows[3];
    run_to_phase(2, "clamp");
    step(1, 3, 15, 10);
    run_to_phase(0, "clamp");
    run_period("clamp", lows);
    checks++;
    if (lows[1] != 10) begin
      errors++;
      $display("FAIL clamp_on_count got %0d want 10", lows[1]);
    end
  endtask

  task automatic test_wrap_load();
    int lows[3];
    run_to_phase(9, "wrapld");
    step(1, 7, 15, 10);
    run_period("wrapld", lows);
    checks++;
    if (lows[0] != 7) begin
      errors++;
      $display("FAIL wrap_cycle_load got %0d want 7", lows[0]);
    end
    run_to_phase(4, "lastwins");
    step(1, 2, 15, 10);
    run_to_phase(8, "lastwins");
    step(1, 5, 15, 10);
    run_to_phase(0, "lastwins");
    run_period("lastwins", lows);
    checks++;
    if (lows[0] != 5) begin
      errors++;
      $display("FAIL last_load_wins got %0d want 5", lows[0]);
    end
  endtask

  task automatic test_enable();
    int lows[3];
    run_to_phase(3, "enable");
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0);
      checks++;
      if (obs !== 4'b1110) begin
        errors++;
        $display("FAIL enable_off cyc %0d got %b want 1110", k, obs);
      end
    end
    en = 1'b1;
    run_period("enable", lows);
    checks++;
    if (lows[0] != 5 || lows[1] != 10 || lows[2] != 10) begin
      errors++;
      $display("FAIL enable_resume got %0d/%0d/%0d want 5/10/10", lows[0], lows[1], lows[2]);
    end
  endtask

  task automatic test_async_reset();
    int lows[3];
    run_to_phase(2, "areset");
    checks++;
    if (led_r !== 1'b0) begin
      errors++;
      $display("FAIL areset_pre led_r got %b want 0", led_r);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 4'b1110) begin
      errors++;
      $display("FAIL areset_immediate got %b want 1110", obs);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    run_period("areset", lows);
    checks++;
    if (lows[0] != 0) begin
      errors++;
      $display("FAIL areset_duty_lost got %0d want 0", lows[0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 15) != 0);
      step(($urandom_range(0, 3) == 0), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    en            = 1'b0;
    bus.duty_load = 1'b0;
    bus.duty_r    = '0;
    bus.duty_g    = '0;
    bus.duty_b    = '0;
    test_reset();
    test_basic_duty();
    test_clamp();
    test_wrap_load();
    test_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
